// File: rtl/camera_pkg.sv
// Shared definitions for the camera-path blocks: classifier FSM states,
// default frame geometry and a percentage helper for elaboration-time
// threshold constants.
package camera_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    EVAL    = 2'd2,
    PUBLISH = 2'd3
  } zc_state_t;

  localparam int DEFAULT_H_PIXELS = 32'sd320;
  localparam int DEFAULT_V_LINES  = 32'sd240;

  // Integer percentage of a pixel count, floor division.
  function automatic int pct_of(input int total, input int pct);
    return (total * pct) / 32'sd100;
  endfunction

endpackage

// File: rtl/zone_argmax_seq.sv
// Sequential argmax over the per-zone count array. A start pulse samples
// zone 0 immediately; each following cycle examines one more zone. done
// pulses for one cycle once the last zone has been examined, and index/value
// then hold the winner. Strict greater-than keeps ties on the lowest index.
module zone_argmax_seq
  import camera_pkg::*;
#(
  parameter int NUM_ZONES = 32'sd3,
  parameter int CNT_W     = 32'sd17,
  localparam int ZONE_W   = $clog2(NUM_ZONES)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [NUM_ZONES-1:0][CNT_W-1:0]   counts,
  output logic                              done,
  output logic [ZONE_W-1:0]                 index,
  output logic [CNT_W-1:0]                  value
);

  logic              busy_r;
  logic [ZONE_W-1:0] cur_r;

  // Walk the zones one per cycle, keeping the running maximum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r <= 1'b0;
      cur_r  <= '0;
      done   <= 1'b0;
      index  <= '0;
      value  <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy_r <= 1'b1;
        cur_r  <= ZONE_W'(1);
        index  <= '0;
        value  <= counts[0];
      end else if (busy_r) begin
        if (counts[cur_r] > value) begin
          index <= cur_r;
          value <= counts[cur_r];
        end
        if (cur_r == ZONE_W'(NUM_ZONES - 1)) begin
          busy_r <= 1'b0;
          done   <= 1'b1;
        end else begin
          cur_r <= cur_r + ZONE_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/zone_classifier.sv
// Per-frame colour-zone classifier. Counts target pixels per vertical zone
// across a frame, checks line/pixel framing, and at frame end publishes the
// dominant zone, the total count, a detect flag and an integrity flag.
// Optional build macro: ZONE_CLASSIFIER_HYST_EN selects a two-threshold
// (hysteresis) detect rule instead of the single on-threshold rule.
module zone_classifier
  import camera_pkg::*;
#(
  parameter int H_PIXELS       = DEFAULT_H_PIXELS,
  parameter int V_LINES        = DEFAULT_V_LINES,
  parameter int NUM_ZONES      = 32'sd3,
  parameter int THRESH_PCT     = 32'sd25,
  parameter int THRESH_OFF_PCT = 32'sd15,
  localparam int ZONE_W        = $clog2(NUM_ZONES),
  localparam int CNT_W         = $clog2(H_PIXELS * V_LINES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vsync,
  input  logic              href,
  input  logic              pix_en,
  input  logic              is_target,
  output logic              result_valid,
  output logic              target_detected,
  output logic [ZONE_W-1:0] best_zone,
  output logic [CNT_W-1:0]  total_count,
  output logic              frame_error
);

  // x saturates at H_PIXELS (meaning "line already full"); the line counter
  // saturates one past V_LINES so an over-long frame still reads as wrong.
  localparam int XW        = $clog2(H_PIXELS + 1);
  localparam int LW        = $clog2(V_LINES + 2);
  localparam int FRAME_PIX = H_PIXELS * V_LINES;
  localparam int THRESH_ON = pct_of(FRAME_PIX, THRESH_PCT);

  if (NUM_ZONES < 2 || THRESH_OFF_PCT > THRESH_PCT) begin : g_bad_cfg
    $error("zone_classifier: NUM_ZONES must be >= 2 and THRESH_OFF_PCT <= THRESH_PCT");
  end

  zc_state_t state_r;
  zc_state_t state_s;

  logic vsync_r;
  logic href_r;
  logic vsync_rise_s;
  logic vsync_fall_s;
  logic href_fall_s;

  logic clear_s;
  logic pix_take_s;
  logic line_end_s;
  logic frame_end_s;
  logic load_s;

  logic [XW-1:0]                    x_r;
  logic [LW-1:0]                    line_r;
  logic                             err_r;
  logic [CNT_W-1:0]                 total_r;
  logic [NUM_ZONES-1:0][CNT_W-1:0]  zone_cnt_r;
  logic [ZONE_W-1:0]                zone_s;

  logic              arg_done_s;
  logic [ZONE_W-1:0] arg_idx_s;
  logic [CNT_W-1:0]  arg_val_s;

  logic over_on_s;
  logic detect_s;
`ifdef ZONE_CLASSIFIER_HYST_EN
  localparam int THRESH_OFF = pct_of(FRAME_PIX, THRESH_OFF_PCT);
  logic under_off_s;
`endif

  // Registered copies of the framing strobes for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_r <= 1'b0;
      href_r  <= 1'b0;
    end else begin
      vsync_r <= vsync;
      href_r  <= href;
    end
  end

  assign vsync_rise_s = vsync & ~vsync_r;
  assign vsync_fall_s = ~vsync & vsync_r;
  assign href_fall_s  = href_r & ~href;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and per-state control strobes. The vsync-rise cycle does no
  // counting, so the zone counts are already final when the argmax starts.
  always_comb begin
    state_s     = state_r;
    clear_s     = 1'b0;
    pix_take_s  = 1'b0;
    line_end_s  = 1'b0;
    frame_end_s = 1'b0;
    load_s      = 1'b0;
    case (state_r)
      IDLE: begin
        clear_s = vsync_fall_s;
        state_s = vsync_fall_s ? ACTIVE : IDLE;
      end
      ACTIVE: begin
        frame_end_s = vsync_rise_s;
        pix_take_s  = ~vsync_rise_s & href & pix_en;
        line_end_s  = ~vsync_rise_s & href_fall_s;
        state_s     = vsync_rise_s ? EVAL : ACTIVE;
      end
      EVAL: begin
        load_s  = arg_done_s;
        state_s = arg_done_s ? PUBLISH : EVAL;
      end
      PUBLISH: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Zone of the current column: highest zone whose lower bound is <= x.
  always_comb begin
    zone_s = '0;
    for (int k = 1; k < NUM_ZONES; k++) begin
      zone_s = (x_r >= XW'(k * H_PIXELS / NUM_ZONES)) ? ZONE_W'(k) : zone_s;
    end
  end

  // Column/line/zone/total counters and the frame-integrity flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_r        <= '0;
      line_r     <= '0;
      err_r      <= 1'b0;
      total_r    <= '0;
      zone_cnt_r <= '0;
    end else if (clear_s) begin
      x_r        <= '0;
      line_r     <= '0;
      err_r      <= 1'b0;
      total_r    <= '0;
      zone_cnt_r <= '0;
    end else begin
      if (pix_take_s) begin
        if (x_r < XW'(H_PIXELS)) begin
          x_r <= x_r + XW'(1);
          if (is_target) begin
            zone_cnt_r[zone_s] <= zone_cnt_r[zone_s] + CNT_W'(1);
            total_r            <= total_r + CNT_W'(1);
          end
        end else begin
          err_r <= 1'b1;
        end
      end
      if (line_end_s) begin
        x_r <= '0;
        if (line_r < LW'(V_LINES + 1)) begin
          line_r <= line_r + LW'(1);
        end
        if (x_r != XW'(H_PIXELS)) begin
          err_r <= 1'b1;
        end
      end
      if (frame_end_s && (line_r != LW'(V_LINES))) begin
        err_r <= 1'b1;
      end
    end
  end

  zone_argmax_seq #(
    .NUM_ZONES (NUM_ZONES),
    .CNT_W     (CNT_W)
  ) u_argmax (
    .clk    (clk),
    .reset  (reset),
    .start  (frame_end_s),
    .counts (zone_cnt_r),
    .done   (arg_done_s),
    .index  (arg_idx_s),
    .value  (arg_val_s)
  );

  // Detect decision for the frame being published; error frames never detect.
  always_comb begin
    over_on_s = (total_r > CNT_W'(THRESH_ON));
`ifdef ZONE_CLASSIFIER_HYST_EN
    under_off_s = (total_r <= CNT_W'(THRESH_OFF));
    if (err_r) begin
      detect_s = 1'b0;
    end else if (over_on_s) begin
      detect_s = 1'b1;
    end else if (under_off_s) begin
      detect_s = 1'b0;
    end else begin
      detect_s = target_detected;
    end
`else
    detect_s = over_on_s & ~err_r;
`endif
  end

  // Published results: loaded as the FSM enters PUBLISH, held until the next.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_valid    <= 1'b0;
      target_detected <= 1'b0;
      best_zone       <= '0;
      total_count     <= '0;
      frame_error     <= 1'b0;
    end else begin
      result_valid <= load_s;
      if (load_s) begin
        best_zone       <= (arg_val_s == '0) ? '0 : arg_idx_s;
        total_count     <= total_r;
        frame_error     <= err_r;
        target_detected <= detect_s;
      end
    end
  end

endmodule

// File: tb/tb_zone_classifier.sv
// Scoreboard bench for zone_classifier on a reduced 32x8 frame, 3 zones
// (bounds 0/10/21, widths 10/11/11), on-threshold 64, off-threshold 38.
module tb_zone_classifier;

  localparam int H  = 32;
  localparam int V  = 8;
  localparam int NZ = 3;
  localparam int ZW = $clog2(NZ);
  localparam int CW = $clog2(H * V + 1);
`ifdef ZONE_CLASSIFIER_HYST_EN
  localparam bit HYST = 1'b1;
`else
  localparam bit HYST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          vsync;
  logic          href;
  logic          pix_en;
  logic          is_target;
  logic          result_valid;
  logic          target_detected;
  logic [ZW-1:0] best_zone;
  logic [CW-1:0] total_count;
  logic          frame_error;

  typedef struct {
    int total;
    int best;
    int det;
    int err;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  zone_classifier #(
    .H_PIXELS       (H),
    .V_LINES        (V),
    .NUM_ZONES      (NZ),
    .THRESH_PCT     (25),
    .THRESH_OFF_PCT (15)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .vsync           (vsync),
    .href            (href),
    .pix_en          (pix_en),
    .is_target       (is_target),
    .result_valid    (result_valid),
    .target_detected (target_detected),
    .best_zone       (best_zone),
    .total_count     (total_count),
    .frame_error     (frame_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every result_valid pulse must match the oldest pending frame.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (result_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_valid: result_valid high at cycle %0d, no frame pending", cyc);
      end else begin
        e = q.pop_front();
        check("total_count", int'(total_count), e.total);
        check("best_zone", int'(best_zone), e.best);
        check("target_detected", int'(target_detected), e.det);
        check("frame_error", int'(frame_error), e.err);
        check("valid_latency", cyc, e.cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One active line; gappy inserts a non-strobed (but target-flagged) cycle
  // after every 4th pixel, which must not be counted.
  task automatic drive_line(input int npix, input int lo, input int hi, input bit gappy);
    for (int x = 0; x < npix; x++) begin
      href      = 1'b1;
      pix_en    = 1'b1;
      is_target = (x >= lo) && (x <= hi);
      @(negedge clk);
      if (gappy && (x % 4 == 3)) begin
        pix_en    = 1'b0;
        is_target = 1'b1;
        @(negedge clk);
      end
    end
    href      = 1'b0;
    pix_en    = 1'b0;
    is_target = 1'b0;
    tick(3);
  endtask

  task automatic run_frame(input int nlines, input int lo, input int hi, input int long_line,
                           input bit gappy, input int e_total, input int e_best,
                           input int e_det, input int e_err);
    exp_t e;
    vsync = 1'b1;
    tick(2);
    vsync = 1'b0;
    tick(2);
    for (int l = 0; l < nlines; l++) begin
      drive_line((l == long_line) ? H + 1 : H, lo, hi, gappy);
    end
    vsync   = 1'b1;
    e.total = e_total;
    e.best  = e_best;
    e.det   = e_det;
    e.err   = e_err;
    e.cyc   = cyc + 1 + NZ;
    q.push_back(e);
    tick(10);
    check("result_published", q.size(), 0);
    q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_result_valid"}, int'(result_valid), 0);
    check({tag, "_target_detected"}, int'(target_detected), 0);
    check({tag, "_best_zone"}, int'(best_zone), 0);
    check({tag, "_total_count"}, int'(total_count), 0);
    check({tag, "_frame_error"}, int'(frame_error), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    vsync     = 1'b1;
    href      = 1'b0;
    pix_en    = 1'b0;
    is_target = 1'b0;
    tick(3);
    check_outputs_zero("reset");
    reset = 1'b0;
    tick(2);

    // All target: zones 80/88/88, tie -> zone 1, 256 > 64.
    run_frame(V, 0, H - 1, -1, 1'b0, 256, 1, 1, 0);
    // Columns 0..8 with strobe gaps: 72 in zone 0, detect.
    run_frame(V, 0, 8, -1, 1'b1, 72, 0, 1, 0);
    // Columns 0..5: 48, between thresholds (held with hysteresis).
    run_frame(V, 0, 5, -1, 1'b0, 48, 0, int'(HYST), 0);
    // Columns 0..3: 32, below off-threshold.
    run_frame(V, 0, 3, -1, 1'b0, 32, 0, 0, 0);
    // No targets at all.
    run_frame(V, 1, 0, -1, 1'b0, 0, 0, 0, 0);
    // Columns 24..31: exactly 64 -> not above threshold, zone 2.
    run_frame(V, 24, 31, -1, 1'b0, 64, 2, 0, 0);
    // Seven lines: counts published, error set, detect forced off.
    run_frame(V - 1, 0, H - 1, -1, 1'b0, 224, 1, 0, 1);
    // One 33-pixel line: extra pixel ignored, error set.
    run_frame(V, 0, H - 1, 3, 1'b0, 256, 1, 0, 1);

    // Reset in the middle of an active frame; that frame must not publish.
    vsync = 1'b1;
    tick(2);
    vsync = 1'b0;
    tick(2);
    for (int l = 0; l < 3; l++) drive_line(H, 0, H - 1, 1'b0);
    href      = 1'b1;
    pix_en    = 1'b1;
    is_target = 1'b1;
    reset     = 1'b1;
    #1;
    check_outputs_zero("midframe_reset");
    tick(2);
    reset     = 1'b0;
    href      = 1'b0;
    pix_en    = 1'b0;
    is_target = 1'b0;
    tick(2);
    for (int l = 0; l < 5; l++) drive_line(H, 0, H - 1, 1'b0);
    vsync = 1'b1;
    tick(10);

    // Next full frame publishes normally.
    run_frame(V, 0, H - 1, -1, 1'b0, 256, 1, 1, 0);

    check("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/zone_classifier.md
# zone_classifier

Parametrised per-frame colour-zone classifier for the camera path. Consumes the per-pixel `is_target` flag from the colour-threshold stage with camera framing (`vsync`, `href`, `pix_en`). Accumulates target-pixel counts per vertical zone over a full frame. At each frame end it publishes the dominant zone, the total count, a thresholded detect flag and a frame-integrity flag to the motion controller.

## Interface
- `H_PIXELS`, 320, active pixels per line
- `V_LINES`, 240, active lines per frame
- `NUM_ZONES`, 3, vertical zones (≥2); zone k covers columns [k*H_PIXELS/NUM_ZONES, (k+1)*H_PIXELS/NUM_ZONES), floor division
- `THRESH_PCT`, 25, detect-on threshold, percent of H_PIXELS*V_LINES
- `THRESH_OFF_PCT`, 15, detect-off threshold (used only with hysteresis)

- `clk` in 1 pixel clock
- `reset` in 1 asynchronous, active-high reset
- `vsync` in 1 high during vertical blanking
- `href` in 1 high during active line
- `pix_en` in 1 pixel strobe; a pixel is counted only when `href && pix_en`
- `is_target` in 1 pixel classified as target colour
- `result_valid` out 1 one-cycle pulse when results update
- `target_detected` out 1 frame detect flag
- `best_zone` out $clog2(NUM_ZONES) zone with the highest count
- `total_count` out CNT_W frame target count; CNT_W = $clog2(H_PIXELS*V_LINES+1)
- `frame_error` out 1 last frame had a wrong line or pixel count

## Operation
- FSM states: IDLE, ACTIVE, EVAL, PUBLISH.
- IDLE: wait for the `vsync` falling edge. On that edge, clear all counters and go to ACTIVE.
- ACTIVE:
  - Column counter x increments per counted pixel.
  - If `is_target` and x < H_PIXELS, the matching zone counter and the total counter increment.
  - If x ≥ H_PIXELS, the pixel is ignored and `err` is set.
  - On each `href` falling edge:
    - if x ≠ H_PIXELS, set `err`;
    - reset x to 0;
    - increment the line counter.
  - On the `vsync` rising edge:
    - if the line count ≠ V_LINES, set `err`;
    - go to EVAL.
- EVAL: one zone per cycle over NUM_ZONES cycles. Compute a running argmax using strict greater-than, so ties go to the lowest index.
- PUBLISH, held for one cycle:
  - register `best_zone`, `total_count` and `frame_error`;
  - update `target_detected`;
  - pulse `result_valid`;
  - go to IDLE.
- Detect rule: `target_detected` = `total_count` > H_PIXELS*V_LINES*THRESH_PCT/100. The constant is computed at elaboration.
- A frame with `err` still publishes its counts, but `target_detected` is forced to 0.
- All-zero frame: `best_zone` = 0 and `target_detected` = 0.
- Counters are sized for the full frame and cannot overflow.
- Framing edges use registered copies of `vsync` and `href`.
- `vsync`, `href` and `pix_en` are ignored outside their relevant state.
- `reset`, including mid-frame:
  - all outputs go to 0 and the FSM goes to IDLE;
  - no `result_valid` until a complete frame has been accumulated from a fresh `vsync` falling edge.

## Timing
- The `vsync` rising edge is detected in cycle T, when the registered `vsync` was 0 and `vsync` is 1.
- `result_valid` is high in cycle T+NUM_ZONES+1 and the outputs are valid from that cycle.
- Outputs hold until the next PUBLISH.
- A pixel present in the same cycle as the `href` falling edge is not counted, because `href` is already low.
- Reset values: `result_valid` 0, `target_detected` 0, `best_zone` 0, `total_count` 0, `frame_error` 0.

## Configuration
- `ZONE_CLASSIFIER_HYST_EN` defined:
  - `target_detected` sets when total > on-threshold (THRESH_PCT);
  - it clears when total ≤ off-threshold (THRESH_OFF_PCT);
  - it otherwise holds its previous value;
  - an error frame still clears it.
- `ZONE_CLASSIFIER_HYST_EN` undefined: single-threshold rule; THRESH_OFF_PCT is unused.

## Structure
- Package `camera_pkg` holds the FSM state enum `zc_state_t` and the default frame-geometry constants (320, 240).
- One sub-module, `zone_argmax_seq`: the sequential argmax over the zone-count array, with start, done, index and value outputs. The top-level contains framing, counters, FSM and detect logic.

## Test plan
Defaults: 320×240, 3 zones, zone bounds 0/106/213, on-threshold 19200, off-threshold 11520.
- All pixels target → `total_count` 76800, `best_zone` 1 (107*240 tie between zones 1 and 2 goes to the lower index), `target_detected` 1, `result_valid` at T+4.
- Target in columns 250–319 on all lines → total 16800, `best_zone` 2, `target_detected` 0.
- Target in columns 0–99 on all lines → total 24000, `best_zone` 0, `target_detected` 1.
- Frame with 239 lines, or one 321-pixel line → `frame_error` 1, `target_detected` 0, `result_valid` still pulses.
- `reset` asserted mid-ACTIVE → all outputs 0 immediately; no `result_valid` at that frame's `vsync` rise; the next full frame publishes normally.
- With `ZONE_CLASSIFIER_HYST_EN`, frame totals 24000 → 15000 → 10000 → `target_detected` 1, 1, 0. Without the macro → 1, 0, 0.
